// File: rtl/ube_dma_chan.sv
// Multi-channel DMA address/word-count register bank with a shared round-robin
// increment arbiter. Each service bumps one channel's address by its stride and its count by one.
module ube_dma_chan #(
   parameter int CHANNELS = 2,
   parameter int AWIDTH   = 18,
   parameter int WCWIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        devRESET,
   input  logic                        devHIBYTE,
   input  logic                        devLOBYTE,
   input  logic [35:0]                 devDATAI,
   input  logic [CHANNELS-1:0]         baWRITE,
   input  logic [CHANNELS-1:0]         wcWRITE,
   input  logic [CHANNELS-1:0]         incREQ,
   input  logic [2*CHANNELS-1:0]       incSIZE,
   output logic [CHANNELS-1:0]         incGNT,
   output logic [AWIDTH*CHANNELS-1:0]  regBA,
   output logic [WCWIDTH*CHANNELS-1:0] regWC,
   output logic [CHANNELS-1:0]         tcDONE
);

   localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [AWIDTH-1:0]     ba [CHANNELS];
   logic [WCWIDTH-1:0]    wc [CHANNELS];
   logic [CHANNELS-1:0]   tcReg;
   logic [CHANNELS-1:0]   gntReg;
   logic [PW-1:0]         nextPtr;

   logic                  anyLane;
   logic [35:0]           laneMask;
   logic [CHANNELS-1:0]   eligible;
   logic [2*CHANNELS-1:0] eligDbl;
   logic [2*CHANNELS-1:0] eligRot;
   logic                  svcValid;
   logic [PW-1:0]         svcIdx;
   logic [CHANNELS-1:0]   svcOh;

   function automatic logic [PW-1:0] wrapIdx(input int v);
      return PW'(v % CHANNELS);
   endfunction

   function automatic logic [AWIDTH-1:0] strideOf(input logic [1:0] code);
      case (code)
         2'd0:    return AWIDTH'(1);
         2'd1:    return AWIDTH'(2);
         default: return AWIDTH'(4);
      endcase
   endfunction

   // The high lane covers every bit above 7, so extended address bits follow devHIBYTE.
   assign anyLane  = devHIBYTE | devLOBYTE;
   assign laneMask = {{28{devHIBYTE}}, {8{devLOBYTE}}};

   // A same-cycle register write blocks the increment; the request stays pending.
   assign eligible = incREQ & ~tcReg & ~baWRITE & ~wcWRITE;
   assign eligDbl  = {eligible, eligible};
   assign eligRot  = eligDbl >> nextPtr;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      svcValid = 1'b0;
      svcIdx   = '0;
      svcOh    = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (!svcValid && eligRot[k]) begin
            svcValid = 1'b1;
            svcIdx   = wrapIdx(int'(nextPtr) + k);
         end
      end
      if (svcValid) svcOh[svcIdx] = 1'b1;
   end

   // NOTE: state updates use non-blocking assignments so every channel sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            ba[c] <= '0;
            wc[c] <= '0;
         end
         tcReg   <= '0;
         gntReg  <= '0;
         nextPtr <= '0;
      end else if (devRESET) begin
         for (int c = 0; c < CHANNELS; c++) begin
            ba[c] <= '0;
            wc[c] <= '0;
         end
         tcReg   <= '0;
         gntReg  <= '0;
         nextPtr <= '0;
      end else begin
         gntReg <= svcOh;
         if (svcValid) nextPtr <= wrapIdx(int'(svcIdx) + 1);
         for (int c = 0; c < CHANNELS; c++) begin
            if (baWRITE[c] && anyLane)
               ba[c] <= (ba[c] & ~laneMask[AWIDTH-1:0]) | (devDATAI[AWIDTH-1:0] & laneMask[AWIDTH-1:0]);
            else if (svcOh[c])
               ba[c] <= ba[c] + strideOf(incSIZE[2*c +: 2]);

            if (wcWRITE[c] && anyLane) begin
               wc[c]    <= (wc[c] & ~laneMask[WCWIDTH-1:0]) | (devDATAI[WCWIDTH-1:0] & laneMask[WCWIDTH-1:0]);
               tcReg[c] <= 1'b0;
            end else if (svcOh[c]) begin
               wc[c] <= wc[c] + WCWIDTH'(1);
               if (&wc[c]) tcReg[c] <= 1'b1;
            end
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : gPack
      assign regBA[c*AWIDTH +: AWIDTH]   = ba[c];
      assign regWC[c*WCWIDTH +: WCWIDTH] = wc[c];
   end

   assign incGNT = gntReg;
   assign tcDONE = tcReg;

endmodule

// File: tb/tb_ube_dma_chan.sv
// Directed bench for ube_dma_chan (2 channels, 18-bit address, 16-bit count):
// a table of per-cycle stimulus/expected-state records plus hand-written reset sequences.
module tb_ube_dma_chan;

   logic        clk = 1'b0;
   logic        rst;
   logic        devRESET, devHIBYTE, devLOBYTE;
   logic [35:0] devDATAI;
   logic [1:0]  baWRITE, wcWRITE, incREQ;
   logic [3:0]  incSIZE;
   logic [1:0]  incGNT;
   logic [35:0] regBA;
   logic [31:0] regWC;
   logic [1:0]  tcDONE;

   int checks = 0;
   int errors = 0;

   ube_dma_chan #(.CHANNELS(2), .AWIDTH(18), .WCWIDTH(16)) dut (
      .clk(clk), .rst(rst), .devRESET(devRESET), .devHIBYTE(devHIBYTE),
      .devLOBYTE(devLOBYTE), .devDATAI(devDATAI), .baWRITE(baWRITE),
      .wcWRITE(wcWRITE), .incREQ(incREQ), .incSIZE(incSIZE), .incGNT(incGNT),
      .regBA(regBA), .regWC(regWC), .tcDONE(tcDONE)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rs, hi, lo;
      logic [35:0] data;
      logic [1:0]  baw, wcw, req;
      logic [3:0]  sz;
      logic [1:0]  gnt;
      logic [17:0] ba0, ba1;
      logic [15:0] wc0, wc1;
      logic [1:0]  tc;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   function automatic vec_t mkVec(
      input logic rs, hi, lo, input logic [35:0] data,
      input logic [1:0] baw, wcw, req, input logic [3:0] sz,
      input logic [1:0] gnt, input logic [17:0] ba0, ba1,
      input logic [15:0] wc0, wc1, input logic [1:0] tc);
      vec_t v;
      v.rs = rs; v.hi = hi; v.lo = lo; v.data = data;
      v.baw = baw; v.wcw = wcw; v.req = req; v.sz = sz;
      v.gnt = gnt; v.ba0 = ba0; v.ba1 = ba1; v.wc0 = wc0; v.wc1 = wc1; v.tc = tc;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkState(input string tag, input logic [1:0] gnt,
                             input logic [17:0] ba0, ba1, input logic [15:0] wc0, wc1,
                             input logic [1:0] tc);
      check({tag, ".gnt"}, 64'(incGNT), 64'(gnt));
      check({tag, ".ba0"}, 64'(regBA[17:0]), 64'(ba0));
      check({tag, ".ba1"}, 64'(regBA[35:18]), 64'(ba1));
      check({tag, ".wc0"}, 64'(regWC[15:0]), 64'(wc0));
      check({tag, ".wc1"}, 64'(regWC[31:16]), 64'(wc1));
      check({tag, ".tc"},  64'(tcDONE), 64'(tc));
   endtask

   task automatic idleInputs();
      devRESET = 0; devHIBYTE = 0; devLOBYTE = 0; devDATAI = '0;
      baWRITE = '0; wcWRITE = '0; incREQ = '0; incSIZE = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //              rs hi lo data        baw    wcw    req    sz       gnt    ba0       ba1       wc0       wc1       tc
      vecs[0]  = mkVec(0, 1, 1, 36'h0FFFC, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00, 18'h0FFFC, 18'h00000, 16'h0000, 16'h0000, 2'b00);
      vecs[1]  = mkVec(0, 1, 1, 36'h0FFFE, 2'b00, 2'b01, 2'b00, 4'b0000, 2'b00, 18'h0FFFC, 18'h00000, 16'hFFFE, 16'h0000, 2'b00);
      vecs[2]  = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b01, 4'b0010, 2'b01, 18'h10000, 18'h00000, 16'hFFFF, 16'h0000, 2'b00);
      vecs[3]  = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b01, 4'b0010, 2'b01, 18'h10004, 18'h00000, 16'h0000, 16'h0000, 2'b01);
      vecs[4]  = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b01, 4'b0010, 2'b00, 18'h10004, 18'h00000, 16'h0000, 16'h0000, 2'b01);
      vecs[5]  = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b01, 4'b0010, 2'b00, 18'h10004, 18'h00000, 16'h0000, 16'h0000, 2'b01);
      vecs[6]  = mkVec(0, 1, 1, 36'h3FFFF, 2'b10, 2'b00, 2'b01, 4'b0010, 2'b00, 18'h10004, 18'h3FFFF, 16'h0000, 16'h0000, 2'b01);
      vecs[7]  = mkVec(0, 1, 1, 36'h00005, 2'b00, 2'b10, 2'b00, 4'b0000, 2'b00, 18'h10004, 18'h3FFFF, 16'h0000, 16'h0005, 2'b01);
      vecs[8]  = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b10, 4'b0000, 2'b10, 18'h10004, 18'h00000, 16'h0000, 16'h0006, 2'b01);
      vecs[9]  = mkVec(0, 1, 1, 36'h00000, 2'b00, 2'b01, 2'b10, 4'b1001, 2'b10, 18'h10004, 18'h00004, 16'h0000, 16'h0007, 2'b00);
      vecs[10] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b1001, 2'b01, 18'h10006, 18'h00004, 16'h0001, 16'h0007, 2'b00);
      vecs[11] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b1001, 2'b10, 18'h10006, 18'h00008, 16'h0001, 16'h0008, 2'b00);
      vecs[12] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b1001, 2'b01, 18'h10008, 18'h00008, 16'h0002, 16'h0008, 2'b00);
      vecs[13] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b1001, 2'b10, 18'h10008, 18'h0000C, 16'h0002, 16'h0009, 2'b00);
      vecs[14] = mkVec(0, 1, 1, 36'h01234, 2'b10, 2'b00, 2'b10, 4'b1000, 2'b00, 18'h10008, 18'h01234, 16'h0002, 16'h0009, 2'b00);
      vecs[15] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b10, 4'b1000, 2'b10, 18'h10008, 18'h01238, 16'h0002, 16'h000A, 2'b00);
      vecs[16] = mkVec(0, 1, 1, 36'h01200, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00, 18'h01200, 18'h01238, 16'h0002, 16'h000A, 2'b00);
      vecs[17] = mkVec(0, 0, 1, 36'h3FFAB, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00, 18'h012AB, 18'h01238, 16'h0002, 16'h000A, 2'b00);
      vecs[18] = mkVec(0, 1, 0, 36'h2CDFF, 2'b10, 2'b00, 2'b00, 4'b0000, 2'b00, 18'h012AB, 18'h2CD38, 16'h0002, 16'h000A, 2'b00);
      vecs[19] = mkVec(0, 0, 0, 36'hFFFFF, 2'b11, 2'b11, 2'b00, 4'b0000, 2'b00, 18'h012AB, 18'h2CD38, 16'h0002, 16'h000A, 2'b00);
      vecs[20] = mkVec(1, 1, 1, 36'h05555, 2'b01, 2'b00, 2'b11, 4'b0101, 2'b00, 18'h00000, 18'h00000, 16'h0000, 16'h0000, 2'b00);
      vecs[21] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b0101, 2'b01, 18'h00002, 18'h00000, 16'h0001, 16'h0000, 2'b00);
      vecs[22] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b0101, 2'b10, 18'h00002, 18'h00002, 16'h0001, 16'h0001, 2'b00);
      vecs[23] = mkVec(1, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b0101, 2'b00, 18'h00000, 18'h00000, 16'h0000, 16'h0000, 2'b00);
      vecs[24] = mkVec(0, 0, 0, 36'h0,     2'b00, 2'b00, 2'b11, 4'b0101, 2'b01, 18'h00002, 18'h00000, 16'h0001, 16'h0000, 2'b00);

      idleInputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkState("reset", 2'b00, 18'h0, 18'h0, 16'h0, 16'h0, 2'b00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) begin
         devRESET  = vecs[i].rs;
         devHIBYTE = vecs[i].hi;
         devLOBYTE = vecs[i].lo;
         devDATAI  = vecs[i].data;
         baWRITE   = vecs[i].baw;
         wcWRITE   = vecs[i].wcw;
         incREQ    = vecs[i].req;
         incSIZE   = vecs[i].sz;
         @(posedge clk);
         #1;
         checkState($sformatf("v%0d", i), vecs[i].gnt, vecs[i].ba0, vecs[i].ba1,
                    vecs[i].wc0, vecs[i].wc1, vecs[i].tc);
      end

      // Async reset between edges: outputs must clear before the next edge,
      // and arbitration restarts at channel 0.
      idleInputs();
      incREQ  = 2'b11;
      incSIZE = 4'b0101;
      @(posedge clk);
      #1;
      checkState("preRst", 2'b10, 18'h00002, 18'h00002, 16'h0001, 16'h0001, 2'b00);
      #3;
      rst = 1'b0;
      #2;
      checkState("midRst", 2'b00, 18'h0, 18'h0, 16'h0, 16'h0, 2'b00);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkState("postRst", 2'b01, 18'h00002, 18'h00000, 16'h0001, 16'h0000, 2'b00);

      idleInputs();
      @(posedge clk);
      #1;
      check("idle.gnt", 64'(incGNT), 64'(2'b00));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
